// File: rtl/tt_sweep_pkg.sv
// Shared types and defaults for the truth-table sweep stages.
package tt_sweep_pkg;

    typedef enum logic [1:0] {IDLE, DRIVE, FINISH} tt_state_t;

    localparam int TT_N_IN_DEF   = 3;
    localparam int TT_SETTLE_DEF = 2;

    function automatic int TT_W(input int n);
        return 2 ** n;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Settle-window down-counter: load restarts the window, expire_o is high in its last cycle.
module tt_settle_timer #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= LOAD_VAL;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/tt_sweep_gen.sv
// Exhaustive input sweep of a small combinational block, capturing its truth table
// and comparing it against an expected minterm mask.
module tt_sweep_gen
    import tt_sweep_pkg::*;
#(
    parameter int N_IN   = TT_N_IN_DEF,
    parameter int SETTLE = TT_SETTLE_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [TT_W(N_IN)-1:0]     expected,
    output logic [N_IN-1:0]           abc_o,
    input  logic                      f_i,
    output logic                      busy,
    output logic                      done,
    output logic [TT_W(N_IN)-1:0]     table_o,
    output logic                      match,
    output logic [N_IN:0]             mismatch_cnt
);

    localparam int W = TT_W(N_IN);
    localparam logic [N_IN:0] LAST_IDX = (N_IN + 1)'(W - 1);

    tt_state_t        state_q;
    logic [N_IN:0]    idx_q;
    logic [N_IN-1:0]  abc_q;
    logic [W-1:0]     exp_q;
    logic [W-1:0]     table_q;
    logic [N_IN:0]    mismatch_q;
    logic             busy_q;
    logic             done_q;
    logic             match_q;

    logic             settle_done;
    logic             last_vec;
    logic [N_IN:0]    idx_d;
    logic [N_IN:0]    mismatch_d;
    logic             tmr_load;
    logic             tmr_en;

    assign last_vec   = (idx_q == LAST_IDX);
    assign idx_d      = idx_q + (N_IN + 1)'(1);
    assign mismatch_d = mismatch_q
                      + {{N_IN{1'b0}}, (f_i != exp_q[idx_q[N_IN-1:0]])};

    // The window restarts on an accepted start and on every advance to a new vector.
    assign tmr_load = !abort
                    && (((state_q == IDLE) && start)
                    ||  ((state_q == DRIVE) && settle_done && !last_vec));
    assign tmr_en   = (state_q == DRIVE);

    tt_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (tmr_load),
        .en_i     (tmr_en),
        .expire_o (settle_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            abc_q      <= '0;
            exp_q      <= '0;
            table_q    <= '0;
            mismatch_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            match_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                abc_q   <= '0;
                match_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            exp_q      <= expected;
                            table_q    <= '0;
                            mismatch_q <= '0;
                            match_q    <= 1'b0;
                            idx_q      <= '0;
                            abc_q      <= '0;
                            busy_q     <= 1'b1;
                            state_q    <= DRIVE;
                        end
                    end
                    DRIVE: begin
                        if (settle_done) begin
                            table_q[idx_q[N_IN-1:0]] <= f_i;
                            mismatch_q               <= mismatch_d;
                            // Match is resolved here so it is already valid in the done cycle.
                            if (last_vec) begin
                                state_q <= FINISH;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                abc_q   <= '0;
                                match_q <= (mismatch_d == '0);
                            end else begin
                                idx_q <= idx_d;
                                abc_q <= idx_d[N_IN-1:0];
                            end
                        end
                    end
                    FINISH: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign abc_o        = abc_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign table_o      = table_q;
    assign match        = match_q;
    assign mismatch_cnt = mismatch_q;

endmodule

// File: tb/tb_tt_sweep_gen.sv
// Bench for tt_sweep_gen: a 3-input/settle-2 instance and a 2-input/settle-1 instance.
module tb_tt_sweep_gen;

    localparam int NA  = 3;
    localparam int SA  = 2;
    localparam int NVA = 8;
    localparam int NB  = 2;
    localparam int SB  = 1;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    // Instance A: function given by an arbitrary truth table
    logic [7:0]    func_tt;
    logic          start_a, abort_a, f_a, busy_a, done_a, match_a;
    logic [7:0]    exp_a, tbl_a;
    logic [NA-1:0] abc_a;
    logic [NA:0]   mcnt_a;

    // Instance B: F = A xor B
    logic          start_b, abort_b, f_b, busy_b, done_b, match_b;
    logic [3:0]    exp_b, tbl_b;
    logic [NB-1:0] abc_b;
    logic [NB:0]   mcnt_b;

    assign f_a = func_tt[abc_a];
    assign f_b = abc_b[1] ^ abc_b[0];

    tt_sweep_gen #(.N_IN(NA), .SETTLE(SA)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .expected(exp_a), .abc_o(abc_a), .f_i(f_a), .busy(busy_a),
        .done(done_a), .table_o(tbl_a), .match(match_a), .mismatch_cnt(mcnt_a)
    );

    tt_sweep_gen #(.N_IN(NB), .SETTLE(SB)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .expected(exp_b), .abc_o(abc_b), .f_i(f_b), .busy(busy_b),
        .done(done_b), .table_o(tbl_b), .match(match_b), .mismatch_cnt(mcnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One sweep on instance A, checked cycle by cycle; ab_cyc=0 means no abort.
    task automatic run_a(input logic [7:0] fn, input logic [7:0] ex,
                         input int ab_cyc, input bit hold, input string nm);
        int         last_c;
        int         stop_c;
        bit         aborted;
        bit         bz;
        logic [7:0] mask;
        last_c  = NVA * SA + 1;
        stop_c  = (ab_cyc > 0) ? ab_cyc + 1 : last_c;
        func_tt = fn;
        exp_a   = ex;
        start_a = 1'b1;
        abort_a = 1'b0;
        step();
        if (!hold) start_a = 1'b0;
        exp_a = ~ex;
        for (int c = 1; c <= stop_c; c++) begin
            aborted = (ab_cyc > 0) && (c > ab_cyc);
            bz      = !aborted && (c <= NVA * SA);
            chk($sformatf("%s busy c%0d", nm, c), 32'(busy_a), 32'(bz));
            chk($sformatf("%s abc c%0d", nm, c), 32'(abc_a), bz ? 32'((c - 1) / SA) : 32'd0);
            chk($sformatf("%s done c%0d", nm, c), 32'(done_a), 32'(!aborted && (c == last_c)));
            if (c == ab_cyc) abort_a = 1'b1;
            if (c < stop_c) begin
                step();
                abort_a = 1'b0;
            end
        end
        mask = '0;
        for (int k = 0; k < NVA; k++)
            if (ab_cyc == 0 || (k + 1) * SA < ab_cyc) mask[k] = 1'b1;
        chk({nm, " table"}, 32'(tbl_a), 32'(fn & mask));
        chk({nm, " mcnt"}, 32'(mcnt_a), 32'($countones((fn ^ ex) & mask)));
        chk({nm, " match"}, 32'(match_a), 32'((ab_cyc == 0) && (fn == ex)));
    endtask

    initial begin
        logic [7:0] rf;
        logic [7:0] re;
        int         ra;
        rst_n   = 1'b1;
        start_a = 1'b0; abort_a = 1'b0; exp_a = '0; func_tt = 8'hEA;
        start_b = 1'b0; abort_b = 1'b0; exp_b = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst abc", 32'(abc_a), 0);
        chk("rst busy", 32'(busy_a), 0);
        chk("rst done", 32'(done_a), 0);
        chk("rst table", 32'(tbl_a), 0);
        chk("rst match", 32'(match_a), 0);
        chk("rst mcnt", 32'(mcnt_a), 0);
        step(); step();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // F = A&B | C against matching and one-bit-off masks
        run_a(8'hEA, 8'hEA, 0, 1'b0, "ab_c_match");
        step();
        run_a(8'hEA, 8'hE8, 0, 1'b0, "ab_c_miss");
        step();
        run_a(8'hEA, 8'hEA, 7, 1'b0, "abort7");
        step();

        // Asynchronous reset in cycle 5 of a sweep
        func_tt = 8'hEA; exp_a = 8'hEA; start_a = 1'b1;
        step();
        start_a = 1'b0;
        step(); step(); step();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst abc", 32'(abc_a), 0);
        chk("midrst busy", 32'(busy_a), 0);
        chk("midrst table", 32'(tbl_a), 0);
        chk("midrst mcnt", 32'(mcnt_a), 0);
        chk("midrst match", 32'(match_a), 0);
        #3 rst_n = 1'b1;
        step();
        run_a(8'hEA, 8'hEA, 0, 1'b0, "after_rst");
        step();

        // Start held high through a whole sweep
        run_a(8'h5C, 8'h5C, 0, 1'b1, "hold");
        step();
        chk("hold idle busy", 32'(busy_a), 0);
        chk("hold idle done", 32'(done_a), 0);
        step();
        start_a = 1'b0;
        chk("hold restart busy", 32'(busy_a), 1);
        chk("hold restart abc", 32'(abc_a), 0);
        chk("hold restart table", 32'(tbl_a), 0);
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        chk("hold abort busy", 32'(busy_a), 0);
        step();

        // Start together with abort in IDLE is dropped
        start_a = 1'b1; abort_a = 1'b1;
        step();
        start_a = 1'b0; abort_a = 1'b0;
        chk("start+abort busy", 32'(busy_a), 0);
        step();

        // Randomized functions, masks and abort points
        for (int i = 0; i < 6; i++) begin
            rf = 8'($urandom);
            re = ($urandom_range(0, 1) == 0) ? rf : 8'(rf ^ 8'($urandom));
            ra = ($urandom_range(0, 2) == 0) ? $urandom_range(1, NVA * SA) : 0;
            run_a(rf, re, ra, 1'b0, $sformatf("rnd%0d", i));
            step();
        end

        // Instance B: N_IN=2, SETTLE=1, F = A xor B
        exp_b = 4'h6; start_b = 1'b1;
        step();
        start_b = 1'b0;
        exp_b = 4'h0;
        for (int c = 1; c <= 5; c++) begin
            chk($sformatf("xor busy c%0d", c), 32'(busy_b), 32'(c <= 4));
            chk($sformatf("xor abc c%0d", c), 32'(abc_b), (c <= 4) ? 32'(c - 1) : 32'd0);
            chk($sformatf("xor done c%0d", c), 32'(done_b), 32'(c == 5));
            if (c < 5) step();
        end
        chk("xor table", 32'(tbl_b), 32'h6);
        chk("xor match", 32'(match_b), 1);
        chk("xor mcnt", 32'(mcnt_b), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tt_sweep_gen.md
# tt_sweep_gen

Sequential stimulus-and-capture stage that drives the input vector of a small combinational Boolean block and records its output across all input combinations. On `start` it steps an N-bit vector from 0 to 2^N−1, holds each value for a programmable settle window, and samples the block's output into a truth-table register. At the end it compares the table against an expected minterm mask. It sits directly upstream of the minimised-logic block (for example a 3-input A/B/C → F function) and also consumes that block's output, replacing manual vector sequencing with a self-checking synthesizable sweep.

## Interface
Parameters:
- `N_IN`, default 3: number of function inputs, legal range 1..6.
- `SETTLE`, default 2: cycles each vector is held before F is sampled, ≥1.

Ports:
- `clk`  in  1  single clock; all logic rising-edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  begin sweep; sampled only in IDLE.
- `abort`  in  1  cancel sweep; wins over all other activity.
- `expected`  in  2^N_IN  expected minterm mask; bit i = F for vector i; sampled on the accepted `start`.
- `abc_o`  out  N_IN  vector to the DUT; MSB = A, LSB = last input.
- `f_i`  in  1  DUT output, combinational from `abc_o`.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse, sweep completed.
- `table_o`  out  2^N_IN  captured truth table; bit i = F at vector i.
- `match`  out  1  `table_o == expected`; valid from `done` onward.
- `mismatch_cnt`  out  N_IN+1  number of differing bits.

## Operation
- FSM states: IDLE → DRIVE → FINISH → IDLE.
- IDLE:
  - `abc_o` = 0.
  - On `start`: latch `expected`, clear `table_o`, `mismatch_cnt` and `match`, set idx = 0 and settle count = 0, go to DRIVE.
- DRIVE:
  - `abc_o` = idx; the settle counter counts 0..SETTLE−1.
  - When settle count = SETTLE−1:
    - `table_o[idx] <= f_i`.
    - `mismatch_cnt += (f_i != expected_q[idx])`.
    - If idx = 2^N_IN−1, go to FINISH; else idx+1 and reset the settle count.
- FINISH: one cycle. `done` = 1, `match` <= (`mismatch_cnt` = 0), go to IDLE.
- `abort` in any state: go to IDLE next cycle, no `done`. `table_o` keeps the partial capture, `match` is forced 0, `mismatch_cnt` holds.
- `start` while `busy` is ignored. `start` and `abort` together in IDLE: abort wins, stay IDLE.
- idx is N_IN+1 bits internally so the terminal compare never wraps. `abc_o` = idx[N_IN−1:0].

## Timing
- Reset values: all outputs 0 (`abc_o`, `busy`, `done`, `table_o`, `match`, `mismatch_cnt`); state IDLE.
- Reset asserted mid-sweep clears everything immediately (asynchronous); there is no resume.
- `start` is seen at edge 0:
  - `busy` = 1 from cycle 1 through cycle 2^N_IN·SETTLE.
  - `done` = 1 and `busy` = 0 in cycle 2^N_IN·SETTLE+1.
  - Defaults: `busy` in cycles 1..16, `done` in cycle 17.
- Vector k is driven during cycles k·SETTLE+1 .. (k+1)·SETTLE. `f_i` is sampled at the closing edge of the last of those cycles.
- `match` and the final `mismatch_cnt` are valid in the `done` cycle and hold until the next accepted `start`.
- The earliest new `start` is accepted in the cycle after `done`.

## Structure
- Shared package `tt_sweep_pkg` holds:
  - state enum `tt_state_t` {IDLE, DRIVE, FINISH};
  - localparam helper `TT_W(n) = 2**n`;
  - default constants `TT_N_IN_DEF = 3`, `TT_SETTLE_DEF = 2`.
- One natural sub-module: `tt_settle_timer`, a parameterised down-counter with load/expire, reused by other sweep stages. The FSM, capture and compare stay in the top module.

## Test plan
- N_IN=3, SETTLE=2, DUT F=A·B+C, `expected`=8'hEA, pulse `start`:
  - `abc_o` steps 0..7, two cycles each;
  - `done` in cycle 17;
  - `table_o`=8'hEA, `match`=1, `mismatch_cnt`=0.
- Same DUT, `expected`=8'hE8: `table_o`=8'hEA, `match`=0, `mismatch_cnt`=1.
- `abort` in cycle 7: IDLE in cycle 8, no `done`, `busy`=0, `abc_o`=0, `table_o`[2:0] captured, `match`=0.
- `rst_n` low in cycle 5 mid-sweep: all outputs 0 asynchronously; a following `start` runs a clean sweep and gives `match`=1.
- `start` held high throughout a sweep: exactly one `done`; a new sweep begins in the cycle after `done`.
- SETTLE=1, N_IN=2, DUT F=A⊕B, `expected`=4'h6: `done` in cycle 5, `table_o`=4'h6, `match`=1.
